// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data-memory controller.
package dmem_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_LO_LIMIT = 0;
    localparam int DEF_HI_LIMIT = 255;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Index width for a storage of the given depth; never below one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
// Read data reads back zero on cycles without a read enable.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_HI_LIMIT - DEF_LO_LIMIT + 1,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage itself is never reset; its contents come from the init sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: init sweep FSM, range check and 1-cycle response path
// in front of a dmem_array storage block.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LO_LIMIT = DEF_LO_LIMIT,
    parameter int HI_LIMIT = DEF_HI_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int unsigned DEPTH = unsigned'(HI_LIMIT - LO_LIMIT + 1);
    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam logic [ADDR_W-1:0] LO_ADDR = ADDR_W'(LO_LIMIT);
    localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(HI_LIMIT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;

    logic              arr_we;
    logic              arr_re;
    logic [IDX_W-1:0]  arr_waddr;
    logic [IDX_W-1:0]  arr_raddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              in_range_c;

    assign in_range_c = (int'(req_addr) >= LO_LIMIT) && (int'(req_addr) <= HI_LIMIT);

    // Next-state, sweep pointer, storage port control and response flags.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        arr_we      = 1'b0;
        arr_re      = 1'b0;
        arr_waddr   = IDX_W'(req_addr - LO_ADDR);
        arr_raddr   = IDX_W'(req_addr - LO_ADDR);
        arr_wdata   = req_wdata;

        unique case (state_q)
            INIT: begin
                arr_we    = 1'b1;
                arr_waddr = IDX_W'(ptr_q - LO_ADDR);
                arr_wdata = DATA_W'(ptr_q);
                if (ptr_q == HI_ADDR) begin
                    state_d = READY;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            READY: begin
                if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    if (!in_range_c) begin
                        rsp_err_d = 1'b1;
                    end else if (req_we) begin
                        arr_we = 1'b1;
                    end else begin
                        arr_re = 1'b1;
                    end
                end
                // A request in the same cycle still completes; sweep starts next cycle.
                if (init_req) begin
                    state_d = INIT;
                    ptr_d   = LO_ADDR;
                end
            end
            default: begin
                state_d = INIT;
                ptr_d   = LO_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            ptr_q       <= LO_ADDR;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (int'(DEPTH)),
        .IDX_W  (int'(IDX_W))
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (rsp_rdata)
    );

    assign init_busy = (state_q == INIT);
    assign req_ready = (state_q == READY);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a full-range instance and a 16..31 windowed instance,
// both compared each cycle against an array-based reference model.
module tb_dmem_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int LO1 = 16;
    localparam int HI1 = 31;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]         init_req;
    logic [1:0]         req_valid;
    logic [1:0]         req_we;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;

    logic          rdy0, rdy1, rv0, rv1, er0, er1, ib0, ib1;
    logic [DW-1:0] rd0, rd1;

    int checks   = 0;
    int failures = 0;
    int model_mem [2][256];
    int init_left [2];

    always #5 clk = ~clk;

    dmem_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .init_req  (init_req[0]),
        .req_valid (req_valid[0]),
        .req_ready (rdy0),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rv0),
        .rsp_rdata (rd0),
        .rsp_err   (er0),
        .init_busy (ib0)
    );

    dmem_ctrl #(.LO_LIMIT(LO1), .HI_LIMIT(HI1)) u_lim (
        .clk       (clk),
        .reset     (reset),
        .init_req  (init_req[1]),
        .req_valid (req_valid[1]),
        .req_ready (rdy1),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rv1),
        .rsp_rdata (rd1),
        .rsp_err   (er1),
        .init_busy (ib1)
    );

    function automatic int lo_of(input int i);
        return (i == 0) ? 0 : LO1;
    endfunction

    function automatic int hi_of(input int i);
        return (i == 0) ? 255 : HI1;
    endfunction

    function automatic int depth_of(input int i);
        return hi_of(i) - lo_of(i) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int i, input bit ev, input int erd, input bit eerr);
        logic v, e, b, r;
        logic [DW-1:0] d;
        string s;
        s = (i == 0) ? "main" : "lim";
        v = (i == 0) ? rv0 : rv1;
        e = (i == 0) ? er0 : er1;
        b = (i == 0) ? ib0 : ib1;
        r = (i == 0) ? rdy0 : rdy1;
        d = (i == 0) ? rd0 : rd1;
        chk({s, ".rsp_valid"}, 32'(v), 32'(ev));
        chk({s, ".rsp_rdata"}, 32'(d), 32'(erd));
        chk({s, ".rsp_err"},   32'(e), 32'(eerr));
        chk({s, ".init_busy"}, 32'(b), 32'(init_left[i] > 0));
        chk({s, ".req_ready"}, 32'(r), 32'(init_left[i] == 0));
    endtask

    // Reference behaviour for one clock edge of instance i.
    task automatic model_step(input int i, input bit v, input bit we, input int addr,
                              input int wdata, input bit ireq,
                              output bit ev, output int erd, output bit eerr);
        int p;
        ev = 1'b0; erd = 0; eerr = 1'b0;
        if (init_left[i] > 0) begin
            p = lo_of(i) + depth_of(i) - init_left[i];
            model_mem[i][p] = p % 256;
            init_left[i]--;
        end else begin
            if (v) begin
                ev = 1'b1;
                if (addr < lo_of(i) || addr > hi_of(i)) eerr = 1'b1;
                else if (we) model_mem[i][addr] = wdata;
                else erd = model_mem[i][addr];
            end
            if (ireq) init_left[i] = depth_of(i);
        end
    endtask

    task automatic idle_inputs();
        init_req = '0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic cycle(input int inst, input bit v, input bit we, input int addr,
                         input int wdata, input bit ireq);
        bit ev [2];
        int erd [2];
        bit eerr [2];
        idle_inputs();
        init_req[inst]  = ireq;
        req_valid[inst] = v;
        req_we[inst]    = we;
        req_addr[inst]  = AW'(addr);
        req_wdata[inst] = DW'(wdata);
        for (int i = 0; i < 2; i++) begin
            model_step(i, (i == inst) && v, we, addr, wdata, (i == inst) && ireq,
                       ev[i], erd[i], eerr[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i, ev[i], erd[i], eerr[i]);
        idle_inputs();
    endtask

    task automatic idle();
        cycle(0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Assert reset away from the clock edge and check outputs before any edge.
    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) init_left[i] = depth_of(i);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i, 1'b0, 0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int inst, addr, wdata;
        bit v, we, ireq;

        reset = 1'b0;
        idle_inputs();
        #2;
        do_reset();

        // Sweep length and swept contents.
        n = 0;
        while (ib0 === 1'b1 && n < 1000) begin idle(); n++; end
        chk("sweep_len", 32'(n), 32'd256);
        cycle(0, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("swept_0", 32'(rd0), 32'h00);
        cycle(0, 1'b1, 1'b0, 17, 0, 1'b0);
        chk("swept_17", 32'(rd0), 32'h11);
        cycle(0, 1'b1, 1'b0, 255, 0, 1'b0);
        chk("swept_255", 32'(rd0), 32'hFF);

        // Write then read back-to-back.
        cycle(0, 1'b1, 1'b1, 'h10, 'hA5, 1'b0);
        chk("wr_pulse", 32'(rv0), 32'd1);
        cycle(0, 1'b1, 1'b0, 'h10, 0, 1'b0);
        chk("raw_pulse", 32'(rv0), 32'd1);
        chk("raw_data", 32'(rd0), 32'hA5);

        // Out-of-range accesses on the windowed instance.
        cycle(1, 1'b1, 1'b0, 'h05, 0, 1'b0);
        chk("oor_rd_err", 32'(er1), 32'd1);
        cycle(1, 1'b1, 1'b1, 'h40, 'h99, 1'b0);
        chk("oor_wr_err", 32'(er1), 32'd1);
        cycle(1, 1'b1, 1'b0, 'h10, 0, 1'b0);
        chk("win_rd_10", 32'(rd1), 32'h10);

        // init_req together with a write: write lands, then sweep overwrites.
        cycle(0, 1'b1, 1'b1, 'h20, 'h3C, 1'b1);
        chk("ireq_wr_pulse", 32'(rv0), 32'd1);
        repeat (256) idle();
        chk("ireq_done", 32'(ib0), 32'd0);
        cycle(0, 1'b1, 1'b0, 'h20, 0, 1'b0);
        chk("ireq_rd_20", 32'(rd0), 32'h20);

        // Randomized traffic on both instances.
        for (int k = 0; k < 600; k++) begin
            inst  = int'($urandom_range(0, 1));
            v     = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            addr  = (inst == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 63));
            wdata = int'($urandom_range(0, 255));
            ireq  = (inst == 0) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 39) == 0);
            cycle(inst, v, we, addr, wdata, ireq);
        end
        n = 0;
        while ((ib0 === 1'b1 || ib1 === 1'b1) && n < 1000) begin idle(); n++; end

        // Reset while a response is on the outputs drops it.
        cycle(0, 1'b1, 1'b0, 'h33, 0, 1'b0);
        do_reset();

        // Reset mid-sweep at address 100, then a full restart.
        repeat (100) idle();
        do_reset();
        n = 0;
        while (ib0 === 1'b1 && n < 1000) begin idle(); n++; end
        chk("resweep_len", 32'(n), 32'd256);

        // Request held through the sweep is taken on the first READY cycle.
        do_reset();
        n = 0;
        do begin
            cycle(0, 1'b1, 1'b1, 'h05, 'h77, 1'b0);
            n++;
        end while (rv0 !== 1'b1 && n < 1000);
        chk("held_accept_cycle", 32'(n), 32'd257);
        cycle(0, 1'b1, 1'b0, 'h05, 0, 1'b0);
        chk("held_rd_05", 32'(rd0), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width in bits.
REQ-003 Parameter LO_LIMIT, default 0: lowest implemented address.
REQ-004 Parameter HI_LIMIT, default 255: highest implemented address; LO_LIMIT <= HI_LIMIT < 2**ADDR_W.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 init_req  input  1  one-cycle pulse requesting a re-initialisation sweep without reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  one-cycle response strobe; no backpressure.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  output  1  request address outside [LO_LIMIT, HI_LIMIT].
REQ-016 init_busy  output  1  initialisation sweep in progress.

Function
REQ-017 The FSM SHALL have two states, INIT and READY.
REQ-018 INIT: one word per cycle, mem[p] <= p mod 2**DATA_W, p from LO_LIMIT to HI_LIMIT; after writing HI_LIMIT, go to READY. The sweep takes exactly DEPTH = HI_LIMIT-LO_LIMIT+1 cycles.
REQ-019 init_busy SHALL be 1 exactly when the state is INIT; req_ready SHALL be its inverse.
REQ-020 READY: init_req = 1 SHALL cause a transition to INIT with p = LO_LIMIT. If req_valid is also 1 in that cycle, the request SHALL be accepted and completed, and the sweep SHALL start on the next cycle.
REQ-021 init_req while in INIT SHALL be ignored; the sweep is not restarted.
REQ-022 A handshake occurs when req_valid and req_ready are both 1. There is at most one handshake per cycle.
REQ-023 rsp_valid SHALL be 1 on the cycle after each handshake and 0 otherwise. Fixed latency 1, full throughput.
REQ-024 In-range read: rsp_rdata = mem[req_addr] as sampled at the handshake edge, rsp_err = 0.
REQ-025 In-range write: mem[req_addr] <= req_wdata at the handshake edge, rsp_rdata = 0, rsp_err = 0.
REQ-026 A read immediately following a write to the same address SHALL return the newly written data.
REQ-027 Out-of-range request (read or write): memory unchanged, rsp_rdata = 0, rsp_err = 1.
REQ-028 When rsp_valid = 0, rsp_rdata and rsp_err SHALL be 0.
REQ-029 req_valid during INIT SHALL NOT be accepted and SHALL NOT alter memory; the requester holds it.

Reset
REQ-030 Asserting reset SHALL force, asynchronously: state INIT, p = LO_LIMIT, init_busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-031 Reset asserted mid-sweep or mid-response SHALL abort the sweep and drop the pending response; the sweep restarts from LO_LIMIT after release.
REQ-032 Memory contents SHALL NOT be reset directly; they are defined only once the sweep completes.

Structure
REQ-033 Package dmem_pkg SHALL hold the FSM state type (INIT, READY) and the default parameter constants.
REQ-034 Storage SHALL be a sub-module dmem_array with one write port and one synchronous read port, holding DEPTH x DATA_W with no reset. dmem_ctrl holds the FSM, sweep pointer, range check and response registers.

Verification
REQ-035 Reset, then count cycles -> init_busy = 1 for exactly 256 cycles; after that, reading addresses 0, 17 and 255 returns 0x00, 0x11 and 0xFF.
REQ-036 Write 0xA5 to 0x10, then read 0x10 on the next cycle -> two consecutive rsp_valid pulses; the second returns rsp_rdata = 0xA5 with rsp_err = 0.
REQ-037 LO_LIMIT=16, HI_LIMIT=31: read 0x05 and write 0x40 -> rsp_err = 1 and rsp_rdata = 0; afterwards, reading 0x10 still returns 0x10.
REQ-038 Pulse init_req in READY together with a write of 0x3C to 0x20 -> the write completes and the sweep starts; after 256 cycles, reading 0x20 returns 0x20.
REQ-039 Assert reset at sweep address 100 -> all outputs take their reset values immediately; the sweep restarts at 0 and lasts 256 cycles.
REQ-040 Hold req_valid during INIT with a write of 0x77 to 0x05 -> no rsp_valid until READY; the write is then accepted on the first READY cycle.
